// File: rtl/spi_leader_mc_if.sv
// Word-level host bus of the SPI leader: valid/ready transmit path and pulsed receive path.
interface spi_leader_mc_if #(
  parameter int WIDTH = 8
);
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_last;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;

  modport master (output tx_valid, tx_data, tx_last, input tx_ready, rx_valid, rx_data);
  modport slave  (input tx_valid, tx_data, tx_last, output tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/spi_leader_mc.sv
// Multi-CS SPI leader: configurable word width, all CPOL/CPHA modes, LSB/MSB order,
// multi-word frames with CS held across words and a one-half-period CS-high gap after.
module spi_leader_mc #(
  parameter int WIDTH  = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [CS_W-1:0]   cfg_cs_sel,
  spi_leader_mc_if.slave    bus,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);
  localparam int EC_W = $clog2(2 * WIDTH + 1);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_WAIT, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d, div_q, div_d;
  logic [EC_W-1:0]     edge_cnt_q, edge_cnt_d;
  logic                sclk_q, sclk_d, mosi_q, mosi_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic [WIDTH-1:0]    tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d, last_q, last_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;

  logic                tick, accept, is_sample, ld_cpha, ld_lsb;
  logic [EC_W-1:0]     edge_n;
  logic [WIDTH-1:0]    rx_next;

  function automatic logic out_bit(input logic [WIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    div_d      = div_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;

    tick      = (div_cnt_q == div_q);
    accept    = bus.tx_valid && tx_ready_q;
    edge_n    = edge_cnt_q + EC_W'(1);
    // Sample edges are the odd ones for CPHA=0 and the even ones for CPHA=1.
    is_sample = (edge_n[0] != cpha_q);
    rx_next   = lsb_q ? {miso, rx_sh_q[WIDTH-1:1]} : {rx_sh_q[WIDTH-2:0], miso};
    ld_cpha   = (state_q == S_IDLE) ? cfg_cpha : cpha_q;
    ld_lsb    = (state_q == S_IDLE) ? cfg_lsb_first : lsb_q;

    case (state_q)
      S_IDLE:  sclk_d = cfg_cpol;
      S_WAIT:  sclk_d = cpol_q;
      S_SETUP: begin
        sclk_d = cpol_q;
        if (tick) begin
          state_d    = S_SHIFT;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
        end else div_cnt_d = div_cnt_q + DIV_W'(1);
      end
      S_SHIFT: begin
        if (tick) begin
          div_cnt_d  = '0;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_n;
          if (is_sample) begin
            rx_sh_d = rx_next;
            if (edge_n == (cpha_q ? LAST_EDGE : LAST_EDGE - EC_W'(1))) begin
              rx_valid_d = 1'b1;
              rx_data_d  = rx_next;
            end
          end else if (edge_n != LAST_EDGE) begin
            mosi_d  = out_bit(tx_sh_q, lsb_q);
            tx_sh_d = shift_out(tx_sh_q, lsb_q);
          end
          if (edge_n == LAST_EDGE) begin
            state_d    = S_HOLD;
            edge_cnt_d = '0;
          end
        end else div_cnt_d = div_cnt_q + DIV_W'(1);
      end
      S_HOLD: begin
        if (tick) begin
          div_cnt_d = '0;
          if (last_q) begin
            state_d = S_GAP;
            cs_n_d  = '1;
          end else state_d = S_WAIT;
        end else div_cnt_d = div_cnt_q + DIV_W'(1);
      end
      S_GAP: begin
        if (tick) begin
          state_d   = S_IDLE;
          div_cnt_d = '0;
        end else div_cnt_d = div_cnt_q + DIV_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Accept only happens in IDLE or WAIT; the first word of a frame latches config and CS.
    if (accept) begin
      state_d   = S_SETUP;
      div_cnt_d = '0;
      last_d    = bus.tx_last;
      rx_sh_d   = '0;
      if (!ld_cpha) begin
        mosi_d  = out_bit(bus.tx_data, ld_lsb);
        tx_sh_d = shift_out(bus.tx_data, ld_lsb);
      end else tx_sh_d = bus.tx_data;
      if (state_q == S_IDLE) begin
        cpol_d = cfg_cpol;
        cpha_d = cfg_cpha;
        lsb_d  = cfg_lsb_first;
        div_d  = cfg_div;
        for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = (int'(cfg_cs_sel) != i);
      end
    end

    tx_ready_d = (state_d == S_IDLE) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      div_q      <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      last_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_q      <= div_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      last_q     <= last_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign busy         = (state_q != S_IDLE);
  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign cs_n         = cs_n_q;
endmodule

// File: doc/spi_leader_mc.md
Name: spi_leader_mc

Overview:
Parametrised next-generation SPI leader. It replaces the fixed 8-bit, single-CS, bidirectional-bus transfer engine with configurable word width, multiple chip selects, LSB/MSB-first ordering and multi-word frames. Words enter and leave on separate valid/ready transmit and pulsed receive interfaces, so no tri-state data bus is used. It sits between the host-side controller and the SPI pins, and supports all four CPOL/CPHA modes with a programmable SCLK divider.

Parameters:
WIDTH, 8, bits per SPI word (2..32)
NUM_CS, 4, number of chip-select lines (1..16)
DIV_W, 8, width of clock-divider config field

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
cfg_cpol  in  1  SCLK idle level
cfg_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
cfg_lsb_first  in  1  1 = shift LSB first
cfg_div  in  DIV_W  SCLK half-period = cfg_div+1 clk cycles
cfg_cs_sel  in  $clog2(NUM_CS) (min 1)  target chip select
tx_valid  in  1  word available
tx_ready  out  1  block accepts word this cycle
tx_data  in  WIDTH  word to send
tx_last  in  1  word ends frame; CS deasserts after it
rx_valid  out  1  one-cycle pulse, rx_data valid
rx_data  out  WIDTH  received word (held until next rx_valid)
busy  out  1  frame in progress (CS asserted or end gap)
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Reset (rst=0, async): cs_n all 1, sclk=0, mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, state IDLE, counters 0. tx_ready rises the first clk after release.
- Config latch: cpol, cpha, lsb_first, div and cs_sel are captured on acceptance of the first word of a frame. Changes mid-frame are ignored until IDLE.
- In IDLE: sclk tracks live cfg_cpol.
- Handshake: transfer when tx_valid && tx_ready. tx_ready=1 only in IDLE and WAIT. tx_data and tx_last are captured on accept.
- States:
  - IDLE: on accept -> SETUP. Assert cs_n[cs_sel]=0 next cycle. busy=1.
  - SETUP: one half-period. For CPHA=0, mosi presents the first bit from the SETUP entry. -> SHIFT.
  - SHIFT: 2*WIDTH SCLK edges, each after a half-period of cfg_div+1 clks.
    - CPHA=0: sample miso on odd edges (leading), shift mosi on even edges except the final one.
    - CPHA=1: shift mosi on odd edges (first bit at edge 1), sample on even edges.
    - After the last edge sclk = cpol. rx_valid pulses the cycle after the final sample.
    - -> HOLD.
  - HOLD: one half-period. Then if last -> GAP. Else -> WAIT.
  - WAIT: CS stays low, sclk=cpol, tx_ready=1. On accept -> SETUP with cs unchanged.
  - GAP: cs_n all 1, busy=1 for one half-period -> IDLE.
- Bit order: MSB first unless lsb_first. The rx shift direction matches tx.
- cs_sel >= NUM_CS: transfer runs normally with all cs_n held 1.
- Back-to-back frames: minimum CS-high time is one half-period (GAP).
- cfg_div=0: half-period = 1 clk, so SCLK = clk/2.
- Reset mid-transfer: immediate abort. CS high, no rx_valid, partial word discarded.
- rx has no backpressure. The consumer must take the word within the rx_valid cycle.

Test Plan:
- Mode 0, WIDTH=8, div=1, cs_sel=0, tx 0xA5 last=1, miso looped to mosi -> cs_n=4'b1110 for the frame, 8 rising sclk edges 4 clk apart, single rx_valid with rx_data=0xA5, then cs_n=4'hF and busy falls.
- Mode 3, lsb_first=1, div=2, bench follower returns 0x3C -> sclk idles high, mosi shows bits of tx 0x81 LSB first, rx_data=0x3C.
- Two-word frame 0x12 (last=0) then 0x34 (last=1), cs_sel=2 -> cs_n=4'b1011 continuously across both words, two rx_valid pulses, 16 sample edges, GAP of div+1 clks.
- WAIT stall: first word last=0, tx_valid withheld 50 clks -> CS low, sclk=cpol, tx_ready=1 throughout; resuming completes the frame.
- Reset pulse after 3 bits of 0xFF -> cs_n=4'hF and sclk=0 asynchronously, no rx_valid; the next transfer after release is correct.
- cfg_div changed 1->5 mid-frame -> remaining words keep a 2-clk half-period; the next frame uses 6.
